ps2_receive: RTL and testbench
==============================

# ps2_receive

Device-to-host PS/2 receiver for the mouse link. It sits on the same PS2C/PS2D lines as the host-to-device sender and consumes the frames the mouse produces: acknowledge bytes after a command, then movement data. Each line is synchronised and glitch-filtered, and each 11-bit frame is deserialised. The block checks start, odd parity and stop, then presents each byte with a one-cycle strobe. An optional stage assembles 3-byte mouse movement packets.

## Interface
- FILTER_LEN, 8, consecutive equal qzt_clk samples required before a filtered line changes (1..255)
- TIMEOUT_CYC, 100000, qzt_clk cycles allowed between bit edges inside a frame (2 ms at 50 MHz)
- qzt_clk  in  1  system clock, 50 MHz
- reset_n  in  1  synchronous, active-low reset
- PS2C  in  1  raw PS/2 clock line
- PS2D  in  1  raw PS/2 data line
- busy  in  1  high while the sender owns the bus; receive is inhibited
- data  out  8  last good byte
- valid  out  1  one-cycle strobe, data updated
- err  out  1  one-cycle strobe, frame rejected
- err_code  out  2  01 parity, 10 framing, 11 timeout; holds until next err
- pkt  out  24  {byte2, byte1, byte0}, present only with the macro
- pkt_valid  out  1  one-cycle strobe for pkt

## Operation
- Input conditioning:
  - PS2C and PS2D each pass through a 2-FF synchroniser.
  - Each then passes through a filter. The filtered value takes the new level after FILTER_LEN consecutive equal samples.
  - Filtered values reset to 1.
- fall: registered flag, high one cycle when filtered PS2C goes 1→0. All sampling uses the filtered PS2D in the fall cycle.
- State machine IDLE / SHIFT / CHECK; resets to IDLE.
- IDLE:
  - fall with PS2D=0 is the start bit. Go to SHIFT, bit count = 1, timeout counter cleared.
  - fall with PS2D=1 is ignored; no err.
- SHIFT:
  - Each fall shifts PS2D into a 10-bit register, LSB first: 8 data bits, parity, stop. Bit count increments.
  - The fall that brings the count to 11 moves the state to CHECK.
  - The timeout counter clears on each fall, otherwise increments.
  - Timeout counter reaching TIMEOUT_CYC gives err with err_code 11, then IDLE.
- CHECK (exactly one cycle):
  - stop=0: framing error, err_code 10.
  - Else if XOR of the 8 data bits and parity is 0: parity error, err_code 01.
  - Else data ← byte and valid=1.
  - Framing takes precedence over parity. Always returns to IDLE.
- busy=1 in any state:
  - The state goes to IDLE next cycle, with no err.
  - Falls are ignored while busy=1.
  - The partial frame is discarded.
- data holds its value between strobes. valid and err are never high in the same cycle.

## Timing
- Pin edge to fall: 2 (synchroniser) + FILTER_LEN + 1 cycles.
- Stop-bit fall cycle t: CHECK at t+1; valid or err registered high at t+2 for exactly 1 cycle.
- Timeout err: asserted the cycle after the counter reaches TIMEOUT_CYC.
- Reset values: data=0, valid=0, err=0, err_code=00, pkt=0, pkt_valid=0, state IDLE, counters 0.
- Reset mid-frame: all state cleared on the next edge; no strobe.
- busy rising on the same cycle as the stop-bit fall: the frame is aborted; no valid.

## Configuration
- PS2_RX_PACKET_EN defined:
  - A 2-bit byte index counts each valid byte.
  - A byte at index 0 with bit 3 = 0 is discarded for resync; the index stays 0.
  - On the valid of the index-2 byte, pkt ← {byte, byte1, byte0} and pkt_valid=1 in the same cycle as valid. The index then returns to 0.
  - Any err, or any busy rising edge, returns the index to 0.
- PS2_RX_PACKET_EN not defined: pkt and pkt_valid remain as ports, tied to 0. No packet logic is synthesised.

## Test plan
- Good byte: frame 0xA5 (bits 0,1,0,1,0,0,1,0,1, parity 1, stop 1), 40 µs PS2C period → valid 1 cycle, data=0xA5, err=0.
- Parity error: byte 0x08 sent with parity 1 → err=1, err_code=01, no valid, data unchanged.
- Framing and timeout:
  - Stop bit sent as 0 with a bad parity bit → err_code=10.
  - A separate frame stopped after 5 bits → err_code=11 exactly TIMEOUT_CYC+1 cycles after the last fall.
- Glitch and busy:
  - A PS2C low pulse of FILTER_LEN-1 cycles mid-frame → ignored; byte received correctly.
  - busy pulsed after bit 4 → no valid, no err; the next full frame is received correctly.
- Packet (with the macro):
  - Bytes 0x00, 0x09, 0x10, 0xF0 → 0x00 dropped; pkt=0xF01009 with pkt_valid in the same cycle as the 0xF0 valid.
  - reset_n low mid-frame → all outputs 0 next cycle.

Source files
------------

// File: rtl/ps2_receive.sv
// Purpose : PS/2 device-to-host receiver. It synchronises and filters PS2C/PS2D,
//           deserialises 11-bit frames, checks start/odd parity/stop and strobes each good byte.
// Latency : pin edge to internal fall takes 2 + FILTER_LEN + 1 cycles. valid/err follow the
//           stop-bit fall by 2 cycles.
// Backpressure: none on the output side; strobes are one cycle wide. busy=1 aborts any frame
//           in progress and holds the receiver idle.
// Ports   : qzt_clk, reset_n (sync, active low), PS2C/PS2D raw lines, busy (sender owns bus),
//           data/valid good byte, err/err_code frame reject (01 parity, 10 framing, 11 timeout),
//           pkt/pkt_valid 3-byte mouse packet.
// Option  : define PS2_RX_PACKET_EN to build the packet assembler. Without it pkt and
//           pkt_valid are tied to 0.
module ps2_receive #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        qzt_clk,
  input  logic        reset_n,
  input  logic        PS2C,
  input  logic        PS2D,
  input  logic        busy,
  output logic [7:0]  data,
  output logic        valid,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [23:0] pkt,
  output logic        pkt_valid
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]    FLT_LAST = 8'(FILTER_LEN - 1);
  // The compare fires one count early, so err lands TIMEOUT_CYC+1 cycles after the last fall.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic          c_meta, c_sync, d_meta, d_sync;
  logic          c_filt, d_filt, c_prev, fall;
  logic [7:0]    c_cnt, d_cnt;
  state_t        state, state_nxt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] tmo;
  logic          start, shift_en, tmo_hit, byte_ok, frm_err, par_err;

  // Synchronisers and glitch filters. A filtered line only moves after FILTER_LEN
  // consecutive synchronised samples disagree with it.
  always_ff @(posedge qzt_clk) begin
    if (!reset_n) begin
      c_meta <= 1'b1;
      c_sync <= 1'b1;
      d_meta <= 1'b1;
      d_sync <= 1'b1;
      c_filt <= 1'b1;
      d_filt <= 1'b1;
      c_cnt  <= '0;
      d_cnt  <= '0;
      c_prev <= 1'b1;
      fall   <= 1'b0;
    end else begin
      c_meta <= PS2C;
      c_sync <= c_meta;
      d_meta <= PS2D;
      d_sync <= d_meta;

      if (c_sync != c_filt) begin
        if (c_cnt == FLT_LAST) begin
          c_filt <= c_sync;
          c_cnt  <= '0;
        end else begin
          c_cnt  <= c_cnt + 8'd1;
        end
      end else begin
        c_cnt <= '0;
      end

      if (d_sync != d_filt) begin
        if (d_cnt == FLT_LAST) begin
          d_filt <= d_sync;
          d_cnt  <= '0;
        end else begin
          d_cnt  <= d_cnt + 8'd1;
        end
      end else begin
        d_cnt <= '0;
      end

      c_prev <= c_filt;
      fall   <= c_prev & ~c_filt;
    end
  end

  // Next-state and per-cycle decisions. busy overrides every state.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    tmo_hit   = 1'b0;
    byte_ok   = 1'b0;
    frm_err   = 1'b0;
    par_err   = 1'b0;
    if (busy) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (fall && !d_filt) begin
            state_nxt = SHIFT;
            start     = 1'b1;
          end
        end
        SHIFT: begin
          if (fall) begin
            shift_en = 1'b1;
            if (bit_cnt == 4'd10) state_nxt = CHECK;
          end else if (tmo == TMO_LAST) begin
            tmo_hit   = 1'b1;
            state_nxt = IDLE;
          end
        end
        CHECK: begin
          state_nxt = IDLE;
          if (!shreg[9])           frm_err = 1'b1;
          else if (!(^shreg[8:0])) par_err = 1'b1;
          else                     byte_ok = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge qzt_clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      tmo      <= '0;
      data     <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      state <= state_nxt;
      valid <= byte_ok;
      err   <= tmo_hit | frm_err | par_err;

      if (start) begin
        bit_cnt <= 4'd1;
        tmo     <= '0;
      end else if (shift_en) begin
        // LSB first: after ten shifts shreg holds {stop, parity, data[7:0]}.
        shreg   <= {d_filt, shreg[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
        tmo     <= '0;
      end else if (state == SHIFT) begin
        tmo <= tmo + 1'b1;
      end

      if (byte_ok) data <= shreg[7:0];

      if (tmo_hit)      err_code <= 2'b11;
      else if (frm_err) err_code <= 2'b10;
      else if (par_err) err_code <= 2'b01;
    end
  end

`ifdef PS2_RX_PACKET_EN
  logic [1:0] idx;
  logic [7:0] byte0, byte1;
  logic       busy_q;

  always_ff @(posedge qzt_clk) begin
    if (!reset_n) begin
      idx       <= '0;
      byte0     <= '0;
      byte1     <= '0;
      busy_q    <= 1'b0;
      pkt       <= '0;
      pkt_valid <= 1'b0;
    end else begin
      busy_q    <= busy;
      pkt_valid <= 1'b0;
      if (tmo_hit || frm_err || par_err || (busy && !busy_q)) begin
        idx <= '0;
      end else if (byte_ok) begin
        case (idx)
          2'd0: begin
            // The first packet byte always has bit 3 set; anything else means we are out of step.
            if (shreg[3]) begin
              byte0 <= shreg[7:0];
              idx   <= 2'd1;
            end
          end
          2'd1: begin
            byte1 <= shreg[7:0];
            idx   <= 2'd2;
          end
          2'd2: begin
            pkt       <= {shreg[7:0], byte1, byte0};
            pkt_valid <= 1'b1;
            idx       <= 2'd0;
          end
          default: idx <= 2'd0;
        endcase
      end
    end
  end
`else
  assign pkt       = '0;
  assign pkt_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_receive.sv
// Purpose : self-checking bench for ps2_receive, covering table vectors, a random frame
//           stream against a rule-based model, and hand-written multi-cycle corner cases.
// Latency : not applicable.
// Backpressure: not applicable.
module tb_ps2_receive;

  localparam int F = 4;    // filter length
  localparam int T = 300;  // timeout cycles
  localparam int H = 20;   // PS2C half period in clocks

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2c = 1'b1;
  logic        ps2d = 1'b1;
  logic        busy = 1'b0;
  logic [7:0]  data;
  logic        valid;
  logic        err;
  logic [1:0]  err_code;
  logic [23:0] pkt;
  logic        pkt_valid;

  always #10 clk = ~clk;

  ps2_receive #(.FILTER_LEN(F), .TIMEOUT_CYC(T)) dut (
    .qzt_clk  (clk),
    .reset_n  (reset_n),
    .PS2C     (ps2c),
    .PS2D     (ps2d),
    .busy     (busy),
    .data     (data),
    .valid    (valid),
    .err      (err),
    .err_code (err_code),
    .pkt      (pkt),
    .pkt_valid(pkt_valid)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        is_err;
    logic [1:0]  code;
    logic [7:0]  dat;
    logic        pv;
    logic [23:0] pk;
  } ev_t;
  ev_t evq[$];

  // Every strobe cycle is recorded, so a strobe longer than one cycle shows up as an extra event.
  always @(negedge clk) begin
    if (valid || err || pkt_valid) begin
      evq.push_back('{is_err: err, code: err_code, dat: data, pv: pkt_valid, pk: pkt});
      if (valid && err) begin
        n_cmp++;
        n_bad++;
        $display("FAIL excl: valid=1 and err=1 in the same cycle");
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_bit(input logic b, input bit abort);
    ps2d = b;
    tick(H);
    ps2c = 1'b0;
    if (abort) begin
      // Raise busy during the exact cycle the internal fall is flagged.
      repeat (3 + F) @(posedge clk);
      #1 busy = 1'b1;
      tick(3);
      busy = 1'b0;
    end
    tick(H);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int nbits, input int glitch_bit, input bit abort_stop);
    logic [10:0] bits;
    bits = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      put_bit(bits[i], abort_stop && (i == 10));
      if (i == glitch_bit) begin
        tick(3);
        ps2c = 1'b0;
        tick(F - 1);
        ps2c = 1'b1;
      end
    end
    ps2d = 1'b1;
    tick(12);
  endtask

  task automatic expect_frame(input string nm, input bit e_err, input logic [1:0] e_code,
                              input logic [7:0] e_data);
    check({nm, " events"}, evq.size(), 1);
    if (evq.size() >= 1) begin
      check({nm, " kind"}, {31'd0, evq[0].is_err}, {31'd0, e_err});
      if (e_err) check({nm, " ev_code"}, {30'd0, evq[0].code}, {30'd0, e_code});
      else       check({nm, " ev_data"}, {24'd0, evq[0].dat}, {24'd0, e_data});
    end
    check({nm, " data"}, {24'd0, data}, {24'd0, e_data});
    check({nm, " err_code"}, {30'd0, err_code}, {30'd0, e_code});
    evq.delete();
  endtask

  task automatic expect_none(input string nm);
    check({nm, " no strobe"}, evq.size(), 0);
    evq.delete();
  endtask

  typedef struct {
    logic [7:0] byt;
    logic       par;
    logic       stp;
    bit         e_err;
    logic [1:0] e_code;  // err_code register value after the frame
    logic [7:0] e_data;  // data register value after the frame
  } vec_t;

  initial begin
    vec_t       vt[10];
    logic [7:0] m_data;
    logic [1:0] m_code;
    logic [7:0] rb;
    logic       rp, rs;
    bit         r_err;
    logic [7:0] pbytes[4];

    vt[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 2'b00, 8'hA5};
    vt[1] = '{8'h08, 1'b1, 1'b1, 1'b1, 2'b01, 8'hA5};
    vt[2] = '{8'h3C, 1'b0, 1'b0, 1'b1, 2'b10, 8'hA5};
    vt[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 2'b10, 8'h00};
    vt[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 2'b10, 8'hFF};
    vt[5] = '{8'h7F, 1'b0, 1'b1, 1'b0, 2'b10, 8'h7F};
    vt[6] = '{8'h7F, 1'b1, 1'b0, 1'b1, 2'b10, 8'h7F};
    vt[7] = '{8'h01, 1'b0, 1'b1, 1'b0, 2'b10, 8'h01};
    vt[8] = '{8'hC3, 1'b1, 1'b1, 1'b0, 2'b10, 8'hC3};
    vt[9] = '{8'hC3, 1'b0, 1'b1, 1'b1, 2'b01, 8'hC3};

    // Reset values
    tick(5);
    @(negedge clk);
    check("rst data",      {24'd0, data},     32'd0);
    check("rst valid",     {31'd0, valid},    32'd0);
    check("rst err",       {31'd0, err},      32'd0);
    check("rst err_code",  {30'd0, err_code}, 32'd0);
    check("rst pkt",       {8'd0, pkt},       32'd0);
    check("rst pkt_valid", {31'd0, pkt_valid}, 32'd0);
    reset_n = 1'b1;
    tick(10);
    evq.delete();

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      send_frame(vt[i].byt, vt[i].par, vt[i].stp, 11, -1, 1'b0);
      expect_frame($sformatf("vec%0d", i), vt[i].e_err, vt[i].e_code, vt[i].e_data);
    end
    m_data = 8'hC3;
    m_code = 2'b01;

    // Random frames against the frame rules
    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom);
      rp = ~(^rb);
      if ($urandom_range(3) == 0) rp = ~rp;
      rs = ($urandom_range(4) != 0);
      if (!rs) begin
        r_err = 1'b1; m_code = 2'b10;
      end else if ((^{rb, rp}) == 1'b0) begin
        r_err = 1'b1; m_code = 2'b01;
      end else begin
        r_err = 1'b0; m_data = rb;
      end
      send_frame(rb, rp, rs, 11, -1, 1'b0);
      expect_frame($sformatf("rand%0d", i), r_err, m_code, m_data);
    end

    // Sub-threshold glitch on PS2C mid-frame
    send_frame(8'hA5, 1'b1, 1'b1, 11, 3, 1'b0);
    m_data = 8'hA5;
    expect_frame("glitch", 1'b0, m_code, m_data);

    // busy pulse after bit 4 discards the partial frame
    send_frame(8'h3C, 1'b1, 1'b1, 5, -1, 1'b0);
    busy = 1'b1;
    tick(5);
    busy = 1'b0;
    tick(10);
    expect_none("busy_abort");
    check("busy_abort data", {24'd0, data}, {24'd0, m_data});
    send_frame(8'h5A, 1'b1, 1'b1, 11, -1, 1'b0);
    m_data = 8'h5A;
    expect_frame("after_busy", 1'b0, m_code, m_data);

    // busy rising in the stop-bit fall cycle
    send_frame(8'h66, 1'b1, 1'b1, 11, -1, 1'b1);
    expect_none("busy_stop");
    check("busy_stop data", {24'd0, data}, {24'd0, m_data});

    // Timeout after 5 bits: err exactly T+1 cycles after the last fall
    put_bit(1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    put_bit(1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    ps2d = 1'b0;
    tick(H);
    ps2c = 1'b0;
    for (int k = 1; k <= F + T + 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == H) ps2c = 1'b1;
      if (k == F + T + 3) check("tmo early", {31'd0, err}, 32'd0);
    end
    check("tmo err", {31'd0, err}, 32'd1);
    ps2d = 1'b1;
    tick(5);
    m_code = 2'b11;
    expect_frame("tmo", 1'b1, m_code, m_data);

    // Packet stream: parity error first to realign the index
    send_frame(8'h08, 1'b1, 1'b1, 11, -1, 1'b0);
    m_code = 2'b01;
    expect_frame("pkt_sync", 1'b1, m_code, m_data);
    pbytes[0] = 8'h00;
    pbytes[1] = 8'h09;
    pbytes[2] = 8'h10;
    pbytes[3] = 8'hF0;
    for (int i = 0; i < 4; i++) send_frame(pbytes[i], ~(^pbytes[i]), 1'b1, 11, -1, 1'b0);
    check("pkt events", evq.size(), 4);
    if (evq.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("pkt byte%0d", i), {24'd0, evq[i].dat}, {24'd0, pbytes[i]});
`ifdef PS2_RX_PACKET_EN
        check($sformatf("pkt pv%0d", i), {31'd0, evq[i].pv}, (i == 3) ? 32'd1 : 32'd0);
`else
        check($sformatf("pkt pv%0d", i), {31'd0, evq[i].pv}, 32'd0);
`endif
      end
`ifdef PS2_RX_PACKET_EN
      check("pkt value", {8'd0, evq[3].pk}, 32'h00F01009);
`else
      check("pkt value", {8'd0, evq[3].pk}, 32'd0);
`endif
    end
    evq.delete();
    m_data = 8'hF0;

    // Reset in the middle of a frame
    send_frame(8'h3C, 1'b1, 1'b1, 4, -1, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst data",      {24'd0, data},      32'd0);
    check("midrst err_code",  {30'd0, err_code},  32'd0);
    check("midrst valid",     {31'd0, valid},     32'd0);
    check("midrst err",       {31'd0, err},       32'd0);
    check("midrst pkt",       {8'd0, pkt},        32'd0);
    check("midrst pkt_valid", {31'd0, pkt_valid}, 32'd0);
    tick(5);
    reset_n = 1'b1;
    tick(10);
    expect_none("midrst");
    send_frame(8'h3C, 1'b1, 1'b1, 11, -1, 1'b0);
    expect_frame("after_rst", 1'b0, 2'b00, 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
